// File: rtl/ins_fetch_ctrl.sv
// Instruction fetch sequencer/arbiter: four byte reads assembled big-endian, shared with a byte loader.
// Optional one-entry instruction buffer enabled by defining INS_BUF_EN.
module ins_fetch_ctrl #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_valid,
  output logic [31:0]       fetch_ins,
  output logic              fetch_err,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD, WT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        k_reg, k_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [23:0]       asm_reg, asm_next;
  logic [31:0]       ins_reg, ins_next;
  logic              err_reg, err_next;
  logic              pc_bad;

`ifdef INS_BUF_EN
  logic              buf_valid_reg, buf_valid_next;
  logic [ADDR_W-1:0] buf_pc_reg, buf_pc_next;
  logic [31:0]       buf_ins_reg, buf_ins_next;
  logic              buf_hit;
  assign buf_hit = buf_valid_reg && (fetch_pc[ADDR_W-1:0] == buf_pc_reg);
`endif

  assign pc_bad = (|fetch_pc[1:0]) || (|fetch_pc[31:ADDR_W]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      pc_reg    <= '0;
      asm_reg   <= '0;
      ins_reg   <= '0;
      err_reg   <= 1'b0;
`ifdef INS_BUF_EN
      buf_valid_reg <= 1'b0;
      buf_pc_reg    <= '0;
      buf_ins_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      pc_reg    <= pc_next;
      asm_reg   <= asm_next;
      ins_reg   <= ins_next;
      err_reg   <= err_next;
`ifdef INS_BUF_EN
      buf_valid_reg <= buf_valid_next;
      buf_pc_reg    <= buf_pc_next;
      buf_ins_reg   <= buf_ins_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    pc_next    = pc_reg;
    asm_next   = asm_reg;
    ins_next   = ins_reg;
    err_next   = err_reg;
    mem_rd     = 1'b0;
    ld_ready   = 1'b0;
`ifdef INS_BUF_EN
    buf_valid_next = buf_valid_reg;
    buf_pc_next    = buf_pc_reg;
    buf_ins_next   = buf_ins_reg;
`endif
    case (state_reg)
      IDLE: begin
        ld_ready = !fetch_req;
        if (fetch_req) begin
          if (pc_bad) begin
            state_next = DONE;
            ins_next   = '0;
            err_next   = 1'b1;
`ifdef INS_BUF_EN
          end else if (buf_hit) begin
            state_next = DONE;
            ins_next   = buf_ins_reg;
            err_next   = 1'b0;
`endif
          end else begin
            state_next = RD;
            k_next     = '0;
            pc_next    = fetch_pc[ADDR_W-1:0];
          end
        end
      end
      RD: begin
        mem_rd = 1'b1;
        // read data lags the strobe by one cycle, so byte k-1 arrives while issuing k
        if (k_reg != 2'd0) asm_next = {asm_reg[15:0], mem_rdata};
        k_next = k_reg + 2'd1;
        if (k_reg == 2'd3) state_next = WT;
      end
      WT: begin
        ins_next   = {asm_reg, mem_rdata};
        err_next   = 1'b0;
        state_next = DONE;
`ifdef INS_BUF_EN
        buf_valid_next = 1'b1;
        buf_pc_next    = pc_reg;
        buf_ins_next   = {asm_reg, mem_rdata};
`endif
      end
      DONE: begin
        ld_ready   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
`ifdef INS_BUF_EN
    // any loader write into the buffered word makes the copy stale
    if (ld_valid && ld_ready && (ld_addr[ADDR_W-1:2] == buf_pc_reg[ADDR_W-1:2]))
      buf_valid_next = 1'b0;
`endif
  end

  assign mem_wr      = ld_valid && ld_ready;
  assign mem_wdata   = mem_wr ? ld_data : 8'h00;
  assign mem_addr    = mem_rd ? (pc_reg + ADDR_W'(k_reg)) : (mem_wr ? ld_addr : '0);
  assign fetch_valid = (state_reg == DONE);
  assign fetch_ins   = ins_reg;
  assign fetch_err   = err_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Scoreboard bench for ins_fetch_ctrl: stimulus pushes expected completions and memory reads,
// a negedge monitor pops and compares them against the DUT.
module tb_ins_fetch_ctrl;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_req;
  logic [31:0]       fetch_pc;
  logic              fetch_valid;
  logic [31:0]       fetch_ins;
  logic              fetch_err;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              busy;

  ins_fetch_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_valid(fetch_valid), .fetch_ins(fetch_ins), .fetch_err(fetch_err),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous byte memory, 1-cycle read latency
  logic [7:0] mem [0:127];
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  typedef struct packed {logic [31:0] ins; logic err; logic [31:0] cyc;} exp_t;
  typedef struct packed {logic [ADDR_W-1:0] addr; logic [31:0] cyc;} rd_t;
  exp_t exp_q[$];
  rd_t  rd_q[$];

  int nchecks = 0;
  int nerrors = 0;
  bit mon_en = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void bad_event(string name);
    nchecks++;
    nerrors++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (fetch_valid) begin
        if (exp_q.size() == 0) bad_event("fetch_valid");
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("fetch_ins", fetch_ins, e.ins);
          chk("fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
          chk("fetch_cycle", cyc, e.cyc);
          $display("fetch done: ins=0x%08h err=%0b cycle=%0d", fetch_ins, fetch_err, cyc);
        end
      end
      if (mem_rd) begin
        if (rd_q.size() == 0) bad_event("mem_rd");
        else begin
          rd_t r;
          r = rd_q.pop_front();
          chk("rd_addr", {25'd0, mem_addr}, {25'd0, r.addr});
          chk("rd_cycle", cyc, r.cyc);
        end
      end
      if (mem_rd && mem_wr) bad_event("rd_and_wr");
      if (!mem_rd && !mem_wr) chk("idle_addr", {25'd0, mem_addr}, 32'd0);
    end
  end

  task automatic ld_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    chk("ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("ld_wr", {31'd0, mem_wr}, 32'd1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    $display("load: addr=0x%02h data=0x%02h", a, d);
  endtask

  // called at posedge+1 in IDLE; returns at posedge+1 once the DUT should be idle again
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] ins, input logic err, input bit fast);
    logic [31:0] t0;
    t0 = cyc;
    fetch_req = 1'b1; fetch_pc = pc;
    exp_q.push_back('{ins: ins, err: err, cyc: t0 + (fast ? 32'd1 : 32'd6)});
    if (!fast)
      for (int k = 0; k < 4; k++)
        rd_q.push_back('{addr: pc[ADDR_W-1:0] + ADDR_W'(k), cyc: t0 + 1 + 32'(k)});
    @(posedge clk); #1;
    fetch_req = 1'b0;
    repeat (fast ? 1 : 6) @(posedge clk);
    #1;
    chk("idle_after_fetch", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] t0;
    rst_n = 1'b0; fetch_req = 1'b0; fetch_pc = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_ins", fetch_ins, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_wr", {31'd0, mem_wr}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    ld_write(7'h00, 8'h8C); ld_write(7'h01, 8'h01);
    ld_write(7'h02, 8'h00); ld_write(7'h03, 8'h04);
    ld_write(7'h04, 8'h11); ld_write(7'h05, 8'h22);
    ld_write(7'h06, 8'h33); ld_write(7'h07, 8'h44);

    do_fetch(32'h0, 32'h8C010004, 1'b0, 1'b0);
    do_fetch(32'h2, 32'h0, 1'b1, 1'b1);
    do_fetch(32'h80, 32'h0, 1'b1, 1'b1);
    do_fetch(32'h0001_0000, 32'h0, 1'b1, 1'b1);

    // contention: fetch wins in IDLE, loader goes in DONE
    t0 = cyc;
    fetch_req = 1'b1; fetch_pc = 32'h4;
    ld_valid = 1'b1; ld_addr = 7'h10; ld_data = 8'hAB;
    exp_q.push_back('{ins: 32'h11223344, err: 1'b0, cyc: t0 + 6});
    for (int k = 0; k < 4; k++) rd_q.push_back('{addr: 7'(4 + k), cyc: t0 + 1 + 32'(k)});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("contend_ld_ready_low", {31'd0, ld_ready}, 32'd0);
      @(posedge clk); #1;
      fetch_req = 1'b0;
    end
    @(negedge clk);
    chk("contend_ld_ready_done", {31'd0, ld_ready}, 32'd1);
    chk("contend_wr", {31'd0, mem_wr}, 32'd1);
    chk("contend_addr", {25'd0, mem_addr}, 32'h10);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    $display("contention: loader write at cycle %0d", t0 + 6);

    ld_write(7'h20, 8'h00); ld_write(7'h21, 8'h00);
    ld_write(7'h22, 8'h00); ld_write(7'h23, 8'h08);
    do_fetch(32'h20, 32'h00000008, 1'b0, 1'b0);
    do_fetch(32'h10, 32'hAB000000, 1'b0, 1'b0);

    // reset while reading: only two reads happen, no completion
    t0 = cyc;
    fetch_req = 1'b1; fetch_pc = 32'h0;
    rd_q.push_back('{addr: 7'h0, cyc: t0 + 1});
    rd_q.push_back('{addr: 7'h1, cyc: t0 + 2});
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rd", {31'd0, mem_rd}, 32'd0);
    $display("reset mid-fetch at cycle %0d", t0 + 3);
    repeat (8) @(posedge clk);
    #1;
    do_fetch(32'h0, 32'h8C010004, 1'b0, 1'b0);

`ifdef INS_BUF_EN
    do_fetch(32'h0, 32'h8C010004, 1'b0, 1'b1);
`else
    do_fetch(32'h0, 32'h8C010004, 1'b0, 1'b0);
`endif
    ld_write(7'h02, 8'h55);
    do_fetch(32'h0, 32'h8C015504, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_fetches", 32'(exp_q.size()), 32'd0);
    chk("pending_reads", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
